// File: rtl/cu_micro_sequencer.sv
// Micro-sequencer for the control unit: owns the control address
// register (car), the run/halt state and the microcycle counter.
module cu_micro_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        ctrl_cpu_start,
  input  logic [1:0]  next_addr,
  input  logic        ctrl_global_halt,
  input  logic [7:0]  opcode,
  input  logic        cond_flag,
  output logic [7:0]  car,
  output logic        seq_running,
  output logic        seq_halted,
  output logic        illegal_op,
  output logic [15:0] ucycle_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   exec;
  logic   bad_op;
  logic   seq_ok;
  logic [7:0] car_nxt;

  // A microword executes only while running with start held high
  assign exec   = (state == RUN) && ctrl_cpu_start;
  assign bad_op = (next_addr == 2'b01) && (opcode[7:6] != 2'b00);
  assign seq_ok = exec && !ctrl_global_halt && !bad_op;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; HALT is left only through rst
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (ctrl_cpu_start) state_nxt = RUN;
      RUN: begin
        if (!ctrl_cpu_start)
          state_nxt = IDLE;
        else if (ctrl_global_halt || bad_op)
          state_nxt = HALT;
      end
      HALT:    state_nxt = HALT;
      default: state_nxt = IDLE;
    endcase
  end

  // Status flags decoded from the registered state
  always_comb begin
    seq_running = (state == RUN);
    seq_halted  = (state == HALT);
  end

  // Next control address; holds on halt, illegal dispatch or pause
  always_comb begin
    car_nxt = car;
    if (seq_ok) begin
      unique case (next_addr)
        2'b00: car_nxt = car + 8'd1;
        2'b01: car_nxt = {opcode[5:0], 2'b00};
        2'b10: car_nxt = 8'h00;
        2'b11: car_nxt = cond_flag ? car + 8'd2 : car + 8'd1;
        default: car_nxt = car;
      endcase
    end
  end

  // Control address register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) car <= 8'h00;
    else     car <= car_nxt;
  end

  // Saturating count of executed microcycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ucycle_count <= 16'h0000;
    else if (exec && (ucycle_count != 16'hFFFF))
      ucycle_count <= ucycle_count + 16'd1;
  end

  // Sticky illegal-dispatch flag; a same-cycle halt masks it
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      illegal_op <= 1'b0;
    else if (exec && !ctrl_global_halt && bad_op)
      illegal_op <= 1'b1;
  end

endmodule
